// File: rtl/sfm_lane_packer.sv
// sfm_lane_packer: compacts strobed lanes into dense full-width beats.
// Flush drains the final partial beat and marks it with last_o.
module sfm_lane_packer #(
    parameter int NUM_LANES = 8,
    parameter int WIDTH     = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             enable_i,
    input  logic                             clear_i,
    input  logic                             flush_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [NUM_LANES-1:0][WIDTH-1:0]  data_i,
    input  logic [NUM_LANES-1:0]             strb_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [NUM_LANES-1:0][WIDTH-1:0]  data_o,
    output logic [NUM_LANES-1:0]             strb_o,
    output logic                             last_o,
    output logic                             flush_done_o
);

    localparam int SLOTS = 2 * NUM_LANES;
    localparam int CW    = $clog2(SLOTS + 1);
    localparam int IW    = $clog2(SLOTS);
    localparam logic [CW-1:0] NL = CW'(NUM_LANES);

    logic [SLOTS-1:0][WIDTH-1:0] slots_q, slots_n;
    logic [CW-1:0]               count_q, count_n;
    logic [CW-1:0]               cnt_p, push;
    logic [IW-1:0]               idx;
    logic                        pend_q, done_q;
    logic                        pop, accept, last_hs, empty_fl;

    assign ready_o  = enable_i & ~pend_q & (count_q <= NL);
    assign valid_o  = enable_i & ((count_q >= NL) | (pend_q & (count_q != '0)));
    assign last_o   = valid_o & pend_q & (count_q <= NL);
    assign data_o   = slots_q[NUM_LANES-1:0];
    assign flush_done_o = done_q;

    assign accept   = valid_i & ready_o;
    assign pop      = valid_o & ready_i;
    assign last_hs  = pop & last_o;
    assign empty_fl = pend_q & (count_q == '0);

    // Output strobes: one bit per occupied slot in the head beat.
    always_comb begin
        strb_o = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            strb_o[i] = (count_q > CW'(i));
        end
    end

    // Next slot contents: pop shifts the head beat out, then strobed lanes append.
    always_comb begin
        slots_n = slots_q;
        cnt_p   = count_q;
        push    = '0;
        if (pop) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                slots_n[i] = slots_q[i+NUM_LANES];
            end
            for (int i = NUM_LANES; i < SLOTS; i++) begin
                slots_n[i] = '0;
            end
            cnt_p = (count_q >= NL) ? count_q - NL : '0;
        end
        idx = IW'(cnt_p);
        if (accept) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (strb_i[i]) begin
                    slots_n[idx] = data_i[i];
                    idx          = idx + 1'b1;
                    push         = push + 1'b1;
                end
            end
        end
        count_n = cnt_p + push;
    end

    // State registers; clear beats everything, enable low freezes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slots_q <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clear_i) begin
            slots_q <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (enable_i) begin
            slots_q <= slots_n;
            count_q <= count_n;
            done_q  <= last_hs | empty_fl;
            if (last_hs | empty_fl) begin
                pend_q <= 1'b0;
            end else if (flush_i) begin
                pend_q <= 1'b1;
            end
        end
    end

endmodule
